// File: rtl/display_capture_pkg.sv
// Shared constants for the seven-segment capture path: hex glyph table,
// blank pattern and the anode-strobe to digit-index mapping.
package display_capture_pkg;

    localparam int NDIGITS = 4;

    // Active-high glyphs on g..a, indexed by the hex value they represent.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] BLANK_GLYPH = 7'h7F;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    typedef struct packed {
        logic [3:0] nibble;
        logic       legal;
        logic       blank;
    } seg_decode_t;

    function automatic logic an_single(input logic [3:0] an);
        return (an == AN_DIG0) || (an == AN_DIG1) || (an == AN_DIG2) || (an == AN_DIG3);
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        case (an)
            AN_DIG1: return 2'd1;
            AN_DIG2: return 2'd2;
            AN_DIG3: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/display_capture_seg7hex.sv
// Combinational decoder from active-low segment lines to a hex nibble,
// flagging whether the pattern is a legal glyph or the blank pattern.
module seg7hex
    import display_capture_pkg::*;
(
    input  logic [6:0]  seg,
    output seg_decode_t dec
);

    always_comb begin
        dec       = '0;
        dec.blank = (seg == BLANK_GLYPH);
        for (int i = 0; i < 16; i++) begin
            if (~seg == HEX_GLYPH[i]) begin
                dec.legal  = 1'b1;
                dec.nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/display_capture.sv
// Samples a multiplexed 4-digit seven-segment bus, decodes each settled
// digit and publishes the assembled 16-bit word once all four are captured.
module display_capture
    import display_capture_pkg::*;
#(
    parameter int SYNC    = 1,
    parameter int SEG_LAG = 1,
    parameter int SETTLE  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] value,
    output logic        valid,
    output logic [3:0]  digit_ok,
    output logic        err
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    logic [3:0]  an_s;
    logic [6:0]  seg_s;
    logic [3:0]  an_a;

    generate
        if (SYNC != 0) begin : g_sync
            logic [3:0] an_m, an_q;
            logic [6:0] seg_m, seg_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    an_m  <= '0;
                    an_q  <= '0;
                    seg_m <= '0;
                    seg_q <= '0;
                end else begin
                    an_m  <= an;
                    an_q  <= an_m;
                    seg_m <= seg;
                    seg_q <= seg_m;
                end
            end
            assign an_s  = an_q;
            assign seg_s = seg_q;
        end else begin : g_direct
            assign an_s  = an;
            assign seg_s = seg;
        end

        if (SEG_LAG != 0) begin : g_lag
            logic [3:0] an_d;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) an_d <= '0;
                else        an_d <= an_s;
            end
            assign an_a = an_d;
        end else begin : g_nolag
            assign an_a = an_s;
        end
    endgenerate

    seg_decode_t dec;
    seg7hex u_dec (.seg(seg_s), .dec(dec));

    logic [3:0]  cnt, cnt_nxt;
    logic [3:0]  prev_an;
    logic [6:0]  prev_seg;
    logic        same, accept;
    logic [1:0]  idx;
    logic [15:0] shadow, shadow_nxt;
    logic [3:0]  seen, seen_nxt, ok_nxt;
    logic        err_nxt, publish;

    // cnt is zero after any unqualified cycle, so a nonzero count means the
    // previous pair was qualified and comparing against it is meaningful.
    always_comb begin
        same    = (cnt != 4'd0) && (an_a == prev_an) && (seg_s == prev_seg);
        cnt_nxt = 4'd0;
        accept  = 1'b0;
        if (an_single(an_a)) begin
            if (!same)                cnt_nxt = 4'd1;
            else if (cnt == SETTLE_C) cnt_nxt = cnt;
            else                      cnt_nxt = cnt + 4'd1;
            accept = (cnt_nxt == SETTLE_C) && !(same && (cnt == SETTLE_C));
        end
    end

    always_comb begin
        idx        = an_index(an_a);
        shadow_nxt = shadow;
        seen_nxt   = seen;
        ok_nxt     = digit_ok;
        err_nxt    = 1'b0;
        if (accept) begin
            if (dec.legal) begin
                shadow_nxt[{idx, 2'b00} +: 4] = dec.nibble;
                seen_nxt[idx] = 1'b1;
                ok_nxt[idx]   = 1'b1;
            end else begin
                ok_nxt[idx] = 1'b0;
                err_nxt     = !dec.blank;
            end
        end
        publish = (seen_nxt == 4'hF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            prev_an  <= '0;
            prev_seg <= '0;
            shadow   <= '0;
            seen     <= '0;
            value    <= '0;
            valid    <= 1'b0;
            digit_ok <= '0;
            err      <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            prev_an  <= an_a;
            prev_seg <= seg_s;
            shadow   <= shadow_nxt;
            seen     <= publish ? 4'h0 : seen_nxt;
            digit_ok <= ok_nxt;
            err      <= err_nxt;
            valid    <= publish;
            if (publish) value <= shadow_nxt;
        end
    end

endmodule

// File: tb/tb_display_capture.sv
// Randomized scoreboard bench for display_capture: two instances with
// different sync/settle settings are checked against a run-length model.
module tb_display_capture;

    localparam logic [6:0] TG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] v;
        logic [3:0]  ok;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  an_i = 4'hF;
    logic [6:0]  seg_i = 7'h7F;
    logic [15:0] value0, value1;
    logic        valid0, valid1, err0, err1;
    logic [3:0]  ok0, ok1;

    display_capture #(.SYNC(0), .SEG_LAG(1), .SETTLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .an(an_i), .seg(seg_i),
        .value(value0), .valid(valid0), .digit_ok(ok0), .err(err0));

    display_capture #(.SYNC(1), .SEG_LAG(1), .SETTLE(3)) u1 (
        .clk(clk), .rst_n(rst_n), .an(an_i), .seg(seg_i),
        .value(value1), .valid(valid1), .digit_ok(ok1), .err(err1));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int pos_cnt = 0;
    int rel_cnt = 0;
    bit first_done = 0;

    logic [3:0]  an_h[$];
    logic [6:0]  seg_h[$];
    logic [15:0] m_shadow[2], m_value[2];
    logic [3:0]  m_seen[2], m_ok[2];
    exp_t vq0[$], vq1[$], eq0[$], eq1[$];
    logic [6:0]  lag_seg = 7'h7F;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, pos_cnt);
        end
    endtask

    // Aligned (an, seg) pair seen by an instance at history index j; flops
    // hold zero before the first post-reset sample.
    function automatic logic [10:0] pair_at(input int sy, input int lg, input int j);
        int ia, is;
        logic [3:0] a;
        logic [6:0] s;
        ia = j - 2*sy - lg;
        is = j - 2*sy;
        a = (ia >= 0) ? an_h[ia] : 4'h0;
        s = (is >= 0) ? seg_h[is] : 7'h00;
        return {a, s};
    endfunction

    task automatic model_step(input int k);
        int t, run, sy, st, idx;
        logic [10:0] p;
        logic [6:0]  pat;
        logic [3:0]  nib;
        bit          legal;
        exp_t        e;
        sy = (k == 0) ? 0 : 1;
        st = (k == 0) ? 1 : 3;
        t  = an_h.size() - 1;
        p  = pair_at(sy, 1, t);
        if ($countones(~p[10:7]) != 1) return;
        run = 0;
        for (int j = t; j >= 0 && run <= st; j--) begin
            if (pair_at(sy, 1, j) == p) run++;
            else break;
        end
        if (run != st) return;
        idx = 0;
        for (int i = 0; i < 4; i++) if (!p[7+i]) idx = i;
        pat = ~p[6:0];
        legal = 0;
        nib = 4'h0;
        for (int i = 0; i < 16; i++) if (pat == TG[i]) begin legal = 1; nib = 4'(i); end
        if (legal) begin
            m_shadow[k][idx*4 +: 4] = nib;
            m_seen[k][idx] = 1'b1;
            m_ok[k][idx]   = 1'b1;
        end else begin
            m_ok[k][idx] = 1'b0;
            if (p[6:0] != 7'h7F) begin
                e.cyc = 32'(pos_cnt + 1);
                e.v   = 16'h0;
                e.ok  = m_ok[k];
                if (k == 0) eq0.push_back(e); else eq1.push_back(e);
            end
        end
        if (m_seen[k] == 4'hF) begin
            m_value[k] = m_shadow[k];
            m_seen[k]  = 4'h0;
            e.cyc = 32'(pos_cnt + 1);
            e.v   = m_value[k];
            e.ok  = m_ok[k];
            if (k == 0) vq0.push_back(e); else vq1.push_back(e);
        end
    endtask

    task automatic model_reset();
        an_h.delete();
        seg_h.delete();
        vq0.delete(); vq1.delete(); eq0.delete(); eq1.delete();
        for (int k = 0; k < 2; k++) begin
            m_shadow[k] = '0; m_value[k] = '0; m_seen[k] = '0; m_ok[k] = '0;
        end
    endtask

    // Called at a falling edge; leaves the caller at the next falling edge.
    task automatic drive(input logic [3:0] a, input logic [6:0] s);
        an_i  = a;
        seg_i = s;
        an_h.push_back(a);
        seg_h.push_back(s);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic disp(input logic [3:0] a, input logic [6:0] s);
        drive(a, lag_seg);
        lag_seg = s;
    endtask

    function automatic logic [3:0] sel(input int i);
        logic [3:0] a;
        a = 4'hF;
        a[i] = 1'b0;
        return a;
    endfunction

    task automatic scan(input logic [15:0] d, input int dwell);
        for (int i = 3; i >= 0; i--)
            repeat (dwell) disp(sel(i), ~TG[d[i*4 +: 4]]);
    endtask

    function automatic int stale(input exp_t q[$]);
        int n;
        n = 0;
        foreach (q[i]) if (int'(q[i].cyc) <= pos_cnt) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        pos_cnt++;
        if (valid0) begin
            if (!first_done) begin
                first_done = 1;
                n_cmp++;
                if (pos_cnt - rel_cnt > 8) begin
                    n_err++;
                    $display("FAIL first_valid_latency: got %0d cycles required <= 8", pos_cnt - rel_cnt);
                end
            end
            if (vq0.size() == 0) chk("u0_valid_unexpected", 32'(valid0), 32'h0);
            else begin
                e = vq0.pop_front();
                chk("u0_valid_cycle", 32'(pos_cnt), e.cyc);
                chk("u0_value", 32'(value0), 32'(e.v));
                chk("u0_digit_ok", 32'(ok0), 32'(e.ok));
            end
        end
        if (valid1) begin
            if (vq1.size() == 0) chk("u1_valid_unexpected", 32'(valid1), 32'h0);
            else begin
                e = vq1.pop_front();
                chk("u1_valid_cycle", 32'(pos_cnt), e.cyc);
                chk("u1_value", 32'(value1), 32'(e.v));
                chk("u1_digit_ok", 32'(ok1), 32'(e.ok));
            end
        end
        if (err0) begin
            if (eq0.size() == 0) chk("u0_err_unexpected", 32'(err0), 32'h0);
            else begin
                e = eq0.pop_front();
                chk("u0_err_cycle", 32'(pos_cnt), e.cyc);
                chk("u0_err_digit_ok", 32'(ok0), 32'(e.ok));
            end
        end
        if (err1) begin
            if (eq1.size() == 0) chk("u1_err_unexpected", 32'(err1), 32'h0);
            else begin
                e = eq1.pop_front();
                chk("u1_err_cycle", 32'(pos_cnt), e.cyc);
                chk("u1_err_digit_ok", 32'(ok1), 32'(e.ok));
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_value0"}, 32'(value0), 32'h0);
        chk({tag, "_valid0"}, 32'(valid0), 32'h0);
        chk({tag, "_ok0"},    32'(ok0),    32'h0);
        chk({tag, "_err0"},   32'(err0),   32'h0);
        chk({tag, "_value1"}, 32'(value1), 32'h0);
        chk({tag, "_valid1"}, 32'(valid1), 32'h0);
        chk({tag, "_ok1"},    32'(ok1),    32'h0);
        chk({tag, "_err1"},   32'(err1),   32'h0);
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        lag_seg = 7'h7F;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rel_cnt = pos_cnt;
    endtask

    initial begin
        logic [15:0] d;
        logic [6:0]  g;
        int          act, dw;
        #1 rst_n = 1'b0;
        #1;
        check_zero("reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rel_cnt = pos_cnt;

        repeat (8) scan(16'h1A2F, 1);
        repeat (4) scan(16'hBEEF, 1);

        // Segment-a-only pattern on digit 2, then the other digits only.
        repeat (3) disp(4'b1011, 7'b1111110);
        repeat (2) begin
            disp(sel(3), ~TG[4'h5]); disp(sel(1), ~TG[4'h6]); disp(sel(0), ~TG[4'h7]);
        end
        repeat (2) scan(16'h4321, 1);

        // Blank digit 0 withholds publication.
        repeat (2) begin
            disp(sel(3), ~TG[4'hC]); disp(sel(2), ~TG[4'hD]);
            disp(sel(1), ~TG[4'hE]); disp(sel(0), 7'h7F);
        end
        repeat (3) scan(16'h9876, 4);

        // Bad anodes and a 2-cycle illegal glitch inside a long dwell.
        repeat (3) disp(4'b0011, ~TG[4'h1]);
        repeat (3) disp(4'b1111, ~TG[4'h2]);
        repeat (5) disp(sel(1), ~TG[4'h3]);
        repeat (2) disp(sel(1), 7'b0110110);
        repeat (5) disp(sel(1), ~TG[4'h3]);
        repeat (2) scan(16'h0F0F, 4);

        // Reset after two captured digits.
        disp(sel(3), ~TG[4'hA]);
        disp(sel(2), ~TG[4'hB]);
        disp(sel(1), ~TG[4'hC]);
        chk("pre_reset_stale_v0", 32'(stale(vq0)), 32'h0);
        chk("pre_reset_stale_e0", 32'(stale(eq0)), 32'h0);
        do_reset("midscan");
        repeat (3) scan(16'h5A5A, 3);

        for (int it = 0; it < 300; it++) begin
            act = $urandom_range(0, 9);
            dw  = $urandom_range(1, 4);
            d   = 16'($urandom);
            case (act)
                0, 1, 2, 3, 4: repeat (dw) disp(sel($urandom_range(0, 3)), ~TG[d[3:0]]);
                5: scan(d, dw);
                6: begin
                    g = ($urandom_range(0, 1) != 0) ? 7'h7F : 7'(~TG[d[3:0]]);
                    repeat (dw) disp(4'($urandom), g);
                end
                7: repeat (dw) disp(sel($urandom_range(0, 3)), 7'($urandom));
                8: repeat (dw) disp(sel($urandom_range(0, 3)), 7'h7F);
                default: begin
                    act = $urandom_range(0, 3);
                    repeat (4) disp(sel(act), ~TG[d[3:0]]);
                    repeat (2) disp(sel(act), 7'($urandom));
                    repeat (4) disp(sel(act), ~TG[d[3:0]]);
                end
            endcase
        end
        repeat (6) disp(4'hF, 7'h7F);

        chk("u0_final_value", 32'(value0), 32'(m_value[0]));
        chk("u1_final_value", 32'(value1), 32'(m_value[1]));
        chk("u0_final_digit_ok", 32'(ok0), 32'(m_ok[0]));
        chk("u1_final_digit_ok", 32'(ok1), 32'(m_ok[1]));
        chk("u0_valid_pending", 32'(vq0.size()), 32'h0);
        chk("u1_valid_pending", 32'(vq1.size()), 32'h0);
        chk("u0_err_pending", 32'(eq0.size()), 32'h0);
        chk("u1_err_pending", 32'(eq1.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
